// File: rtl/mips_pkg.sv
// Shared definitions for the memory stage: FSM encoding, byte-enable and
// alignment constants, and the alignment check used on op acceptance.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } mau_state_t;

    localparam logic [3:0] MEM_BE_WORD     = 4'b1111;

    // Low address bits that must be zero for each access size
    localparam logic [1:0] ALIGN_MASK_WORD = 2'b11;
    localparam logic [1:0] ALIGN_MASK_HALF = 2'b01;

    function automatic logic is_misaligned(input logic [1:0] lsb, input logic half);
        logic [1:0] mask;
        mask = half ? ALIGN_MASK_HALF : ALIGN_MASK_WORD;
        return (lsb & mask) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load result formatter: picks the addressed halfword of a little-endian word
// and sign- or zero-extends it; full-word loads pass through unchanged.
module load_extend (
    input  logic [31:0] word,
    input  logic        hi_sel,
    input  logic        half,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [15:0] half_sel;

    // Halfword select and extension
    always_comb begin
        half_sel = hi_sel ? word[31:16] : word[15:0];
        result   = word;
        if (half) begin
            result = is_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage sequencer: turns each accepted load/store into a single
// req/ack transaction, stalls upstream while it is in flight, and reports
// completion, misalignment or timeout with a one-cycle done pulse.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LoadHalf,
    input  logic              LoadHalfUnsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              align_err,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mau_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              we_q, we_d;
    logic              half_q, half_d;
    logic              uns_q, uns_d;
    logic              tmo_q, tmo_d;
    // Bit 0 is only needed for the alignment check, which uses the live input
    logic [ADDR_W-1:1] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       ext_data;
    logic              accept;
    logic              acc_half;

    load_extend u_load_extend (
        .word        (mem_rdata),
        .hi_sel      (addr_q[1]),
        .half        (half_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, operand latching and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        half_d      = half_q;
        uns_d       = uns_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        done        = 1'b0;
        rdata       = '0;
        align_err   = 1'b0;
        timeout_err = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;

        accept   = op_valid & (MemRead | MemWrite);
        // Writes are word-only, so half flags only matter for reads
        acc_half = ~MemWrite & (LoadHalf | LoadHalfUnsigned);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    we_d    = MemWrite;
                    half_d  = acc_half;
                    uns_d   = ~LoadHalf & LoadHalfUnsigned;
                    addr_d  = addr[ADDR_W-1:1];
                    wdata_d = wdata;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    rdata_d = '0;
                    state_d = is_misaligned(addr[1:0], acc_half) ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = wdata_q;
                mem_be    = MEM_BE_WORD;
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : DATA_W'(ext_data);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ERR;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                rdata   = rdata_q;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done        = 1'b1;
                align_err   = ~tmo_q;
                timeout_err = tmo_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            uns_q   <= 1'b0;
            tmo_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            half_q  <= half_d;
            uns_q   <= uns_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of ops with hand-derived results plus
// hand-written timeout, ignored-op and asynchronous reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, MemRead, MemWrite, LoadHalf, LoadHalfUnsigned;
    logic [31:0] addr, wdata;
    logic        stall, done, align_err, timeout_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_valid         (op_valid),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .LoadHalf         (LoadHalf),
        .LoadHalfUnsigned (LoadHalfUnsigned),
        .addr             (addr),
        .wdata            (wdata),
        .stall            (stall),
        .done             (done),
        .rdata            (rdata),
        .align_err        (align_err),
        .timeout_err      (timeout_err),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, lh, lhu;
        logic [31:0] addr, wdata;
        int          ack_dly;
        logic [31:0] mrd;
        logic        exp_align;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        align, tmo, we;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        op_valid = 0; MemRead = 0; MemWrite = 0; LoadHalf = 0; LoadHalfUnsigned = 0;
        addr = 0; wdata = 0;
    endtask

    // Called in the cycle done is expected; pops the scoreboard
    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_stall_low"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req_low"}, {31'd0, mem_req}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_align_err"}, {31'd0, align_err}, {31'd0, e.align});
            chk({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, e.tmo});
            if (!e.we || e.align || e.tmo) chk({tag, "_rdata"}, rdata, e.rdata);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   n;
        @(negedge clk);
        op_valid = 1; MemRead = v.rd; MemWrite = v.wr; LoadHalf = v.lh; LoadHalfUnsigned = v.lhu;
        addr = v.addr; wdata = v.wdata;
        #1 chk({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
        e.align = v.exp_align; e.tmo = 1'b0; e.we = v.exp_we; e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk); #1;
        clear_inputs();
        addr = 32'hFFFF_FFFF;   // inputs are don't-care outside IDLE
        if (v.exp_align) begin
            chk({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
        end else begin
            n = 0;
            while (mem_req && n < 20) begin
                chk({tag, "_stall_hold"}, {31'd0, stall}, 32'd1);
                chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
                chk({tag, "_mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
                chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'hF);
                if (v.exp_we) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
                if (n == v.ack_dly) begin
                    mem_ack = 1; mem_rdata = v.mrd;
                end else begin
                    mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                mem_ack = 0;
                n++;
            end
            chk({tag, "_req_cycles"}, n, v.ack_dly + 1);
        end
        check_done(tag);
        @(posedge clk); #1;
        chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        exp_t e;
        //          rd wr lh lhu addr          wdata         dly mrd           al we  exp_rdata
        vecs[0]  = '{1, 0, 0, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
        vecs[1]  = '{1, 0, 1, 0, 32'h12, 32'h0,        1, 32'h80011234, 0, 0, 32'hFFFF8001};
        vecs[2]  = '{1, 0, 0, 1, 32'h12, 32'h0,        1, 32'h80011234, 0, 0, 32'h00008001};
        vecs[3]  = '{1, 0, 1, 0, 32'h10, 32'h0,        0, 32'h80011234, 0, 0, 32'h00001234};
        vecs[4]  = '{0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 4, 32'h0,        0, 1, 32'h0};
        vecs[5]  = '{1, 0, 0, 0, 32'h13, 32'h0,        0, 32'h0,        1, 0, 32'h0};
        vecs[6]  = '{1, 0, 1, 0, 32'h11, 32'h0,        0, 32'h0,        1, 0, 32'h0};
        vecs[7]  = '{1, 1, 0, 0, 32'h24, 32'h12345678, 2, 32'h0,        0, 1, 32'h0};
        vecs[8]  = '{1, 0, 1, 1, 32'h16, 32'h0,        0, 32'hABCD0000, 0, 0, 32'hFFFFABCD};
        vecs[9]  = '{1, 0, 0, 1, 32'h02, 32'h0,        3, 32'hFFFE0000, 0, 0, 32'h0000FFFE};
        vecs[10] = '{0, 1, 1, 0, 32'h22, 32'h55AA55AA, 0, 32'h0,        1, 1, 32'h0};
        vecs[11] = '{1, 0, 1, 0, 32'h1E, 32'h0,        2, 32'h7FFF0000, 0, 0, 32'h00007FFF};
        vecs[12] = '{1, 0, 0, 0, 32'h30, 32'h0,        7, 32'h0BADF00D, 0, 0, 32'h0BADF00D};

        clear_inputs();
        mem_ack = 0; mem_rdata = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_errs", {30'd0, align_err, timeout_err}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_bus", {mem_addr[27:0], mem_be} | mem_wdata | {31'd0, mem_we}, 32'd0);
        rst_n = 1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Op with neither read nor write is ignored
        @(negedge clk);
        op_valid = 1; LoadHalf = 1; addr = 32'h40;
        #1 chk("nop_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        chk("nop_req", {31'd0, mem_req}, 32'd0);
        chk("nop_done", {31'd0, done}, 32'd0);

        // Timeout: memory never acknowledges
        @(negedge clk);
        op_valid = 1; MemRead = 1; addr = 32'h44;
        e.align = 0; e.tmo = 1; e.we = 0; e.rdata = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        clear_inputs();
        n = 0;
        while (mem_req && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_req_cycles", n, 8);
        check_done("tmo");
        @(posedge clk); #1;
        chk("tmo_done_once", {31'd0, done}, 32'd0);
        run_vec(vecs[0], "after_tmo");

        // Asynchronous reset in the middle of ACCESS
        @(negedge clk);
        op_valid = 1; MemRead = 1; addr = 32'h50;
        @(posedge clk); #1;
        clear_inputs();
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_req", {31'd0, mem_req}, 32'd0);
        chk("rst_async_stall", {31'd0, stall}, 32'd0);
        chk("rst_async_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_idle_req", {31'd0, mem_req}, 32'd0);
            chk("rst_idle_done", {30'd0, done, stall}, 32'd0);
        end
        run_vec(vecs[1], "after_rst");

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
